// File: rtl/axil_pkg.sv
// Shared response codes, FSM state encoding and index helper for the AXI4-Lite register responder.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR    = 3'd1,
    ST_BRESP = 3'd2,
    ST_RD    = 3'd3,
    ST_RRESP = 3'd4
  } state_e;

  function automatic logic idx_in_range(input logic [31:0] idx, input int unsigned depth);
    return idx < depth;
  endfunction

endpackage

// File: rtl/axil_regfile.sv
// DEPTH x 32-bit register array with per-byte write strobes and asynchronous clear.
module axil_regfile #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IDXW  = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_we,
  input  logic [IDXW-1:0] i_widx,
  input  logic [31:0]     i_wdata,
  input  logic [3:0]      i_wstrb,
  input  logic [IDXW-1:0] i_ridx,
  output logic [31:0]     o_rdata
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (i_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (i_wstrb[b]) begin
          mem_q[i_widx][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  assign o_rdata = mem_q[i_ridx];

endmodule

// File: rtl/axil_reg_responder.sv
// AXI4-Lite responder: one transaction at a time, round-robin between simultaneous write and read requests.
module axil_reg_responder
  import axil_pkg::*;
#(
  parameter int unsigned AW    = 12,
  parameter int unsigned DEPTH = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [AW-1:0] i_awaddr,
  input  logic          i_awvalid,
  output logic          o_awready,
  input  logic [31:0]   i_wdata,
  input  logic [3:0]    i_wstrb,
  input  logic          i_wvalid,
  output logic          o_wready,
  output logic [1:0]    o_bresp,
  output logic          o_bvalid,
  input  logic          i_bready,
  input  logic [AW-1:0] i_araddr,
  input  logic          i_arvalid,
  output logic          o_arready,
  output logic [31:0]   o_rdata,
  output logic [1:0]    o_rresp,
  output logic          o_rlast,
  output logic          o_rvalid,
  input  logic          i_rready
);

  localparam int unsigned IW   = AW - 2;
  localparam int unsigned IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e        state_q, state_d;
  logic          rr_q, rr_d;
  logic          aw_held_q, aw_held_d;
  logic          w_held_q, w_held_d;
  logic [IW-1:0] awidx_q, awidx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [1:0]    bresp_q, bresp_d;
  logic [1:0]    rresp_q, rresp_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [IW-1:0] wr_idx, rd_idx;
  logic [31:0]   wr_data, rf_rdata;
  logic [3:0]    wr_strb;
  logic          wr_ok, rd_ok, aw_hs, w_hs, wr_both, rf_we;
  logic          unused_addr_lsbs;

  // A channel accepted this cycle is used directly, so the commit can happen in the handshake cycle.
  assign wr_idx  = aw_held_q ? awidx_q : i_awaddr[AW-1:2];
  assign wr_data = w_held_q ? wdata_q : i_wdata;
  assign wr_strb = w_held_q ? wstrb_q : i_wstrb;
  assign rd_idx  = i_araddr[AW-1:2];
  assign wr_ok   = idx_in_range(32'(wr_idx), DEPTH);
  assign rd_ok   = idx_in_range(32'(rd_idx), DEPTH);
  assign aw_hs   = (state_q == ST_WR) && i_awvalid && !aw_held_q;
  assign w_hs    = (state_q == ST_WR) && i_wvalid && !w_held_q;
  assign wr_both = (aw_held_q || aw_hs) && (w_held_q || w_hs);
  assign rf_we   = (state_q == ST_WR) && wr_both && wr_ok;

  assign unused_addr_lsbs = ^{i_awaddr[1:0], i_araddr[1:0]};

  axil_regfile #(
    .DEPTH (DEPTH),
    .IDXW  (IDXW)
  ) u_regfile (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_we    (rf_we),
    .i_widx  (wr_idx[IDXW-1:0]),
    .i_wdata (wr_data),
    .i_wstrb (wr_strb),
    .i_ridx  (rd_idx[IDXW-1:0]),
    .o_rdata (rf_rdata)
  );

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awidx_d   = awidx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    o_awready = 1'b0;
    o_wready  = 1'b0;
    o_arready = 1'b0;
    o_bvalid  = 1'b0;
    o_rvalid  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((i_awvalid || i_wvalid) && (!i_arvalid || !rr_q)) begin
          state_d = ST_WR;
        end else if (i_arvalid) begin
          state_d = ST_RD;
        end
      end
      ST_WR: begin
        o_awready = !aw_held_q;
        o_wready  = !w_held_q;
        if (aw_hs) begin
          aw_held_d = 1'b1;
          awidx_d   = i_awaddr[AW-1:2];
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = i_wdata;
          wstrb_d  = i_wstrb;
        end
        if (wr_both) begin
          bresp_d = wr_ok ? RESP_OKAY : RESP_SLVERR;
          state_d = ST_BRESP;
        end
      end
      ST_BRESP: begin
        o_bvalid = 1'b1;
        if (i_bready) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          rr_d      = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_RD: begin
        o_arready = 1'b1;
        if (i_arvalid) begin
          rdata_d = rd_ok ? rf_rdata : '0;
          rresp_d = rd_ok ? RESP_OKAY : RESP_SLVERR;
          state_d = ST_RRESP;
        end
      end
      ST_RRESP: begin
        o_rvalid = 1'b1;
        if (i_rready) begin
          rr_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      rr_q      <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awidx_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RESP_OKAY;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awidx_q   <= awidx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  assign o_bresp = bresp_q;
  assign o_rresp = rresp_q;
  assign o_rdata = rdata_q;
  assign o_rlast = 1'b1;

endmodule

// File: tb/tb_axil_reg_responder.sv
// Directed bench: a register-array model predicts every response, checked each cycle the outputs are valid.
module tb_axil_reg_responder;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic [11:0] i_awaddr, i_araddr;
  logic        i_awvalid, i_wvalid, i_arvalid, i_bready, i_rready;
  logic [31:0] i_wdata;
  logic [3:0]  i_wstrb;
  logic        o_awready, o_wready, o_arready, o_bvalid, o_rvalid, o_rlast;
  logic [1:0]  o_bresp, o_rresp;
  logic [31:0] o_rdata;

  always #5 clk = ~clk;

  axil_reg_responder #(
    .AW    (12),
    .DEPTH (16)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (i_rst_n),
    .i_awaddr  (i_awaddr),
    .i_awvalid (i_awvalid),
    .o_awready (o_awready),
    .i_wdata   (i_wdata),
    .i_wstrb   (i_wstrb),
    .i_wvalid  (i_wvalid),
    .o_wready  (o_wready),
    .o_bresp   (o_bresp),
    .o_bvalid  (o_bvalid),
    .i_bready  (i_bready),
    .i_araddr  (i_araddr),
    .i_arvalid (i_arvalid),
    .o_arready (o_arready),
    .o_rdata   (o_rdata),
    .o_rresp   (o_rresp),
    .o_rlast   (o_rlast),
    .o_rvalid  (o_rvalid),
    .i_rready  (i_rready)
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  logic [31:0] model_mem [16];
  bit          model_rr;
  logic [1:0]  exp_b [$];
  logic [33:0] exp_r [$];
  byte         resp_log [$];
  int          b_count = 0, r_count = 0, b_rise_cyc = 0, r_rise_cyc = 0;
  logic        prev_bv = 1'b0, prev_rv = 1'b0;
  logic [31:0] last_rdata = '0;
  logic [1:0]  last_rresp = '0, last_bresp = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic int idx_of(input logic [11:0] a);
    return int'(a[11:2]);
  endfunction

  function automatic logic [1:0] model_write(input logic [11:0] a, input logic [31:0] d,
                                             input logic [3:0] s);
    int i = idx_of(a);
    if (i >= 16) return 2'b10;
    for (int b = 0; b < 4; b++)
      if (s[b]) model_mem[i][8*b +: 8] = d[8*b +: 8];
    return 2'b00;
  endfunction

  function automatic logic [33:0] model_read(input logic [11:0] a);
    int i = idx_of(a);
    if (i >= 16) return {2'b10, 32'h0};
    return {2'b00, model_mem[i]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model_mem[i] = '0;
    model_rr = 1'b0;
  endtask

  // Per-cycle comparison against the model's expected responses.
  always @(negedge clk) begin
    if (!i_rst_n) begin
      chk("awready_in_reset", o_awready, 0);
      chk("wready_in_reset", o_wready, 0);
      chk("arready_in_reset", o_arready, 0);
      chk("bvalid_in_reset", o_bvalid, 0);
      chk("rvalid_in_reset", o_rvalid, 0);
    end else begin
      chk("rlast", o_rlast, 1);
      if (o_bvalid) begin
        if (!prev_bv) b_rise_cyc = cyc;
        if (exp_b.size() == 0) chk("bvalid_unexpected", 1, 0);
        else begin
          chk("bresp", o_bresp, exp_b[0]);
          if (i_bready) begin
            last_bresp = o_bresp;
            void'(exp_b.pop_front());
            resp_log.push_back("W");
            b_count++;
          end
        end
      end
      if (o_rvalid) begin
        if (!prev_rv) r_rise_cyc = cyc;
        if (exp_r.size() == 0) chk("rvalid_unexpected", 1, 0);
        else begin
          chk("rdata", o_rdata, exp_r[0][31:0]);
          chk("rresp", o_rresp, exp_r[0][33:32]);
          if (i_rready) begin
            last_rdata = o_rdata;
            last_rresp = o_rresp;
            void'(exp_r.pop_front());
            resp_log.push_back("R");
            r_count++;
          end
        end
      end
    end
    prev_bv = o_bvalid;
    prev_rv = o_rvalid;
  end

  task automatic wait_b(input int tgt);
    int k = 0;
    while (b_count < tgt && k < 100) begin @(posedge clk); #1; k++; end
    if (b_count < tgt) chk("b_timeout", 0, 1);
  endtask

  task automatic wait_r(input int tgt);
    int k = 0;
    while (r_count < tgt && k < 100) begin @(posedge clk); #1; k++; end
    if (r_count < tgt) chk("r_timeout", 0, 1);
  endtask

  task automatic write_txn(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int lead, output int lat);
    int tgt = b_count + 1;
    int st, k = 0;
    bit aw_done = 0, w_done = 0, awf, wf;
    exp_b.push_back(model_write(a, d, s));
    model_rr = 1'b1;
    i_awaddr = a; i_wdata = d; i_wstrb = s;
    i_wvalid = 1'b1; i_awvalid = (lead == 0);
    st = cyc;
    while (!(aw_done && w_done) && k < 50) begin
      @(negedge clk);
      awf = i_awvalid && o_awready;
      wf  = i_wvalid && o_wready;
      @(posedge clk); #1; k++;
      if (awf) begin aw_done = 1; i_awvalid = 1'b0; end
      if (wf)  begin w_done = 1;  i_wvalid = 1'b0; end
      if (!aw_done && !i_awvalid && k >= lead) i_awvalid = 1'b1;
    end
    if (!(aw_done && w_done)) chk("write_handshake_timeout", 0, 1);
    i_awvalid = 1'b0; i_wvalid = 1'b0;
    wait_b(tgt);
    lat = b_rise_cyc - st;
  endtask

  task automatic read_txn(input logic [11:0] a, input int hold, output int lat);
    int tgt = r_count + 1;
    int st, k = 0;
    bit done = 0, f;
    logic [31:0] first;
    exp_r.push_back(model_read(a));
    model_rr = 1'b0;
    i_araddr = a; i_arvalid = 1'b1;
    if (hold > 0) i_rready = 1'b0;
    st = cyc;
    while (!done && k < 50) begin
      @(negedge clk);
      f = i_arvalid && o_arready;
      @(posedge clk); #1; k++;
      if (f) begin done = 1; i_arvalid = 1'b0; end
    end
    if (!done) chk("read_handshake_timeout", 0, 1);
    i_arvalid = 1'b0;
    if (hold > 0) begin
      k = 0;
      while (!o_rvalid && k < 20) begin @(negedge clk); k++; end
      first = o_rdata;
      repeat (hold) begin
        @(negedge clk);
        chk("rvalid_held", o_rvalid, 1);
        chk("rdata_stable", o_rdata, first);
      end
      @(posedge clk); #1;
      i_rready = 1'b1;
    end
    wait_r(tgt);
    lat = r_rise_cyc - st;
  endtask

  task automatic both_txn(input logic [11:0] wa, input logic [31:0] d, input logic [3:0] s,
                          input logic [11:0] ra);
    int tb = b_count + 1, tr = r_count + 1, k = 0;
    bit awd = 0, wd = 0, ard = 0, awf, wf, arf;
    if (!model_rr) begin
      exp_b.push_back(model_write(wa, d, s));
      exp_r.push_back(model_read(ra));
      model_rr = 1'b0;
    end else begin
      exp_r.push_back(model_read(ra));
      exp_b.push_back(model_write(wa, d, s));
      model_rr = 1'b1;
    end
    i_awaddr = wa; i_wdata = d; i_wstrb = s; i_araddr = ra;
    i_awvalid = 1'b1; i_wvalid = 1'b1; i_arvalid = 1'b1;
    while (!(awd && wd && ard) && k < 100) begin
      @(negedge clk);
      awf = i_awvalid && o_awready;
      wf  = i_wvalid && o_wready;
      arf = i_arvalid && o_arready;
      @(posedge clk); #1; k++;
      if (awf) begin awd = 1; i_awvalid = 1'b0; end
      if (wf)  begin wd = 1;  i_wvalid = 1'b0; end
      if (arf) begin ard = 1; i_arvalid = 1'b0; end
    end
    if (!(awd && wd && ard)) chk("pair_handshake_timeout", 0, 1);
    i_awvalid = 1'b0; i_wvalid = 1'b0; i_arvalid = 1'b0;
    wait_b(tb);
    wait_r(tr);
  endtask

  task automatic chk_order(input string name, input byte first, input byte second);
    int n = resp_log.size();
    if (n < 2) chk({name, "_log_short"}, n, 2);
    else begin
      chk({name, "_first"}, 32'(resp_log[n-2]), 32'(first));
      chk({name, "_second"}, 32'(resp_log[n-1]), 32'(second));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    i_rst_n = 1'b0; i_awaddr = '0; i_araddr = '0; i_wdata = '0; i_wstrb = '0;
    i_awvalid = 1'b0; i_wvalid = 1'b0; i_arvalid = 1'b0; i_bready = 1'b1; i_rready = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_bresp", o_bresp, 0);
    chk("reset_rresp", o_rresp, 0);
    chk("reset_rdata", o_rdata, 0);
    @(posedge clk); #1;
    i_rst_n = 1'b1;
    @(posedge clk); #1;

    // Simultaneous requests straight out of reset: write wins, read sees its data.
    both_txn(12'h00C, 32'h11112222, 4'hF, 12'h00C);
    chk_order("pair1", "W", "R");
    chk("pair1_rdata", last_rdata, 32'h11112222);
    both_txn(12'h00C, 32'h0BADF00D, 4'hF, 12'h00C);
    chk_order("pair2", "W", "R");
    chk("pair2_rdata", last_rdata, 32'h0BADF00D);
    write_txn(12'h010, 32'h5A5A5A5A, 4'hF, 0, lat);
    both_txn(12'h00C, 32'h33334444, 4'hF, 12'h00C);
    chk_order("pair3", "R", "W");
    chk("pair3_rdata_old", last_rdata, 32'h0BADF00D);
    read_txn(12'h00C, 0, lat);
    chk("pair3_readback", last_rdata, 32'h33334444);

    write_txn(12'h008, 32'hDEADBEEF, 4'hF, 0, lat);
    chk("write_latency", lat, 2);
    chk("write_bresp_okay", last_bresp, 2'b00);
    read_txn(12'h008, 0, lat);
    chk("read_latency", lat, 2);
    chk("read_deadbeef", last_rdata, 32'hDEADBEEF);
    chk("read_rresp_okay", last_rresp, 2'b00);

    write_txn(12'h004, 32'hAAAAAAAA, 4'hF, 0, lat);
    write_txn(12'h004, 32'h12345678, 4'h3, 3, lat);
    read_txn(12'h004, 0, lat);
    chk("w_before_aw", last_rdata, 32'hAAAA5678);
    write_txn(12'h004, 32'hFFFFFFFF, 4'h0, 0, lat);
    chk("strb0_bresp", last_bresp, 2'b00);
    read_txn(12'h004, 0, lat);
    chk("strb0_nochange", last_rdata, 32'hAAAA5678);
    write_txn(12'h00B, 32'h77000000, 4'h8, 1, lat);
    read_txn(12'h009, 0, lat);
    chk("top_byte_lsb_ignored", last_rdata, 32'h77ADBEEF);

    write_txn(12'h100, 32'hFFFFFFFF, 4'hF, 0, lat);
    chk("oob_bresp", last_bresp, 2'b10);
    read_txn(12'h100, 0, lat);
    chk("oob_rdata", last_rdata, 32'h0);
    chk("oob_rresp", last_rresp, 2'b10);
    write_txn(12'h03C, 32'hC0FFEE00, 4'hF, 0, lat);
    write_txn(12'h040, 32'h01010101, 4'hF, 0, lat);
    chk("idx16_bresp", last_bresp, 2'b10);
    for (int i = 0; i < 16; i++) read_txn(12'(i * 4), 0, lat);
    chk("idx15_readback", last_rdata, 32'hC0FFEE00);

    read_txn(12'h008, 5, lat);
    chk("held_read_value", last_rdata, 32'h77ADBEEF);

    // Reset while a write has only its address captured.
    i_awaddr = 12'h008; i_awvalid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    i_rst_n = 1'b0;
    i_awvalid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    i_rst_n = 1'b1;
    model_reset();
    repeat (5) begin
      @(negedge clk);
      chk("no_bvalid_after_reset", o_bvalid, 0);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) read_txn(12'(i * 4), 0, lat);
    chk("cleared_after_reset", last_rdata, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
